// File: rtl/gin_bus_sender.sv
`default_nettype none
// ============================================================================
// Module      : gin_bus_sender
// Description : Transmitting end of the GIN tagged-multicast bus. A small FIFO
//               feeds a held output register with per-word delivery counting
//               and a sticky stall indicator.
// Revision    : 1.0 - initial release
// ============================================================================
module gin_bus_sender #(
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_WIDTH   = 4,
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int STALL_LIMIT = 255
) (
  input  logic                     link_clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    src_data,
  input  logic [TAG_WIDTH-1:0]     src_tag,
  input  logic                     src_valid,
  output logic                     src_ready,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [TAG_WIDTH-1:0]     tag_out,
  output logic                     enable_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]     sent_count,
  output logic                     stall_flag,
  input  logic                     clear_stall
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_SW = $clog2(STALL_LIMIT + 1);
  localparam logic [c_AW:0]   c_FULL       = (c_AW + 1)'(DEPTH);
  localparam logic [c_SW-1:0] c_STALL_MAX  = c_SW'(STALL_LIMIT);
  localparam logic [c_SW-1:0] c_STALL_PRE  = c_SW'(STALL_LIMIT - 1);

  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [TAG_WIDTH-1:0]  r_mem_tag  [DEPTH];
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_AW:0]         r_count;
  logic                  r_src_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic                  r_enable;
  logic [CNT_WIDTH-1:0]  r_sent;
  logic [c_SW-1:0]       r_stall_cnt;
  logic                  r_stall_flag;

  logic w_push;
  logic w_pop;
  logic w_done;
  logic w_empty;
  logic w_blocked;
  logic w_stall_hit;

  // r_src_en keeps src_ready low until the first edge after reset release
  assign src_ready   = r_src_en && (r_count != c_FULL);
  assign w_empty     = (r_count == '0);
  assign w_push      = src_valid && src_ready;
  assign w_done      = r_enable && ready_in;
  assign w_pop       = (!r_enable || ready_in) && !w_empty;
  assign w_blocked   = r_enable && !ready_in;
  // Also true once saturated, so a concurrent clear_stall loses while blocked
  assign w_stall_hit = w_blocked && (r_stall_cnt >= c_STALL_PRE);

  assign data_out   = r_data;
  assign tag_out    = r_tag;
  assign enable_out = r_enable;
  assign fifo_count = r_count;
  assign sent_count = r_sent;
  assign stall_flag = r_stall_flag;

  always_ff @(posedge link_clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= src_data;
      r_mem_tag[r_wr_ptr]  <= src_tag;
    end
  end

  always_ff @(posedge link_clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_src_en <= 1'b0;
    end else begin
      r_src_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge link_clk or negedge reset) begin
    if (!reset) begin
      r_data   <= '0;
      r_tag    <= '0;
      r_enable <= 1'b0;
    end else if (w_pop) begin
      r_data   <= r_mem_data[r_rd_ptr];
      r_tag    <= r_mem_tag[r_rd_ptr];
      r_enable <= 1'b1;
    end else if (w_done) begin
      r_data   <= '0;
      r_tag    <= '0;
      r_enable <= 1'b0;
    end
  end

  always_ff @(posedge link_clk or negedge reset) begin
    if (!reset) begin
      r_sent <= '0;
    end else if (w_done) begin
      r_sent <= r_sent + 1'b1;
    end
  end

  always_ff @(posedge link_clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt  <= '0;
      r_stall_flag <= 1'b0;
    end else begin
      if (w_blocked) begin
        if (r_stall_cnt != c_STALL_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
      end else begin
        r_stall_cnt <= '0;
      end
      if (w_stall_hit)      r_stall_flag <= 1'b1;
      else if (clear_stall) r_stall_flag <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gin_bus_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_gin_bus_sender
// Description : Scoreboard bench for gin_bus_sender (bus order, counts, stall).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gin_bus_sender;
  localparam int DW = 64;
  localparam int TW = 4;
  localparam int DEPTH = 4;
  localparam int CW = 16;
  localparam int SL = 8;

  logic          link_clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic [TW-1:0] src_tag = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [DW-1:0] data_out;
  logic [TW-1:0] tag_out;
  logic          enable_out;
  logic          ready_in = 1'b0;
  logic [2:0]    fifo_count;
  logic [CW-1:0] sent_count;
  logic          stall_flag;
  logic          clear_stall = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } word_t;
  word_t exp_q[$];
  bit    sb_on = 1'b0;

  gin_bus_sender #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH), .CNT_WIDTH(CW), .STALL_LIMIT(SL)
  ) dut (
    .link_clk(link_clk), .reset(reset), .src_data(src_data), .src_tag(src_tag),
    .src_valid(src_valid), .src_ready(src_ready), .data_out(data_out),
    .tag_out(tag_out), .enable_out(enable_out), .ready_in(ready_in),
    .fifo_count(fifo_count), .sent_count(sent_count), .stall_flag(stall_flag),
    .clear_stall(clear_stall)
  );

  always #5 link_clk = ~link_clk;

  // Scoreboard: mid-cycle sampling, inputs only change just after posedge
  always @(negedge link_clk) begin
    if (sb_on && reset) begin
      if (enable_out && ready_in) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_order: got unexpected word %h/%h, required none", data_out, tag_out);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          if ({data_out, tag_out} !== w) begin
            failures++;
            $display("FAIL sb_order: got %h/%h required %h/%h", data_out, tag_out, w.d, w.t);
          end
        end
      end
      if (!enable_out) begin
        checks++;
        if (data_out !== '0 || tag_out !== '0) begin
          failures++;
          $display("FAIL idle_zero: got %h/%h required 0/0", data_out, tag_out);
        end
      end
      if (src_valid && src_ready) exp_q.push_back(word_t'({src_data, src_tag}));
    end
  end

  task automatic step();
    @(posedge link_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if (enable_out !== 1'b0 || data_out !== '0 || tag_out !== '0 || fifo_count !== 3'd0
        || sent_count !== '0 || stall_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got en=%b d=%h t=%h cnt=%0d sent=%0d stall=%b required all 0",
               enable_out, data_out, tag_out, fifo_count, sent_count, stall_flag);
    end
    reset = 1'b1;
    step();
    checks++;
    if (src_ready !== 1'b1 || enable_out !== 1'b0 || fifo_count !== 3'd0 || sent_count !== '0) begin
      failures++;
      $display("FAIL reset_idle: got rdy=%b en=%b cnt=%0d sent=%0d required 1 0 0 0",
               src_ready, enable_out, fifo_count, sent_count);
    end
  endtask

  task automatic test_single();
    sb_on = 1'b1;
    ready_in = 1'b1;
    src_data = 64'hDEAD_BEEF_0000_0001;
    src_tag = 4'h3;
    src_valid = 1'b1;
    step();
    src_valid = 1'b0;
    checks++;
    if (enable_out !== 1'b0) begin
      failures++;
      $display("FAIL single_latency: got en=%b required 0", enable_out);
    end
    step();
    checks++;
    if (enable_out !== 1'b1 || data_out !== 64'hDEAD_BEEF_0000_0001 || tag_out !== 4'h3) begin
      failures++;
      $display("FAIL single_word: got en=%b %h/%h required 1 deadbeef00000001/3",
               enable_out, data_out, tag_out);
    end
    step();
    checks++;
    if (enable_out !== 1'b0 || sent_count !== 16'd1) begin
      failures++;
      $display("FAIL single_done: got en=%b sent=%0d required 0 1", enable_out, sent_count);
    end
  endtask

  task automatic test_backpressure();
    ready_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      src_data = 64'h1000_0000_0000_0000 + 64'(i);
      src_tag = 4'(i + 8);
      src_valid = 1'b1;
      step();
    end
    src_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (src_ready !== 1'b0 || fifo_count !== 3'd4 || enable_out !== 1'b1
          || data_out !== 64'h1000_0000_0000_0000 || tag_out !== 4'h8) begin
        failures++;
        $display("FAIL bp_full: got rdy=%b cnt=%0d en=%b %h/%h required 0 4 1 1000000000000000/8",
                 src_ready, fifo_count, enable_out, data_out, tag_out);
      end
      step();
    end
    ready_in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (enable_out !== (i < 5)) begin
        failures++;
        $display("FAIL bp_drain: cycle %0d got en=%b required %b", i, enable_out, (i < 5));
      end
    end
    checks++;
    if (sent_count !== 16'd6 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL bp_sent: got sent=%0d cnt=%0d required 6 0", sent_count, fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    ready_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      src_data = {32'hC0FF_EE00, 32'(i)};
      src_tag = 4'(i);
      src_valid = 1'b1;
      step();
      checks++;
      if (fifo_count !== 3'd1 || enable_out !== (i >= 2)) begin
        failures++;
        $display("FAIL stream: cycle %0d got cnt=%0d en=%b required 1 %b",
                 i, fifo_count, enable_out, (i >= 2));
      end
    end
    src_valid = 1'b0;
    repeat (2) step();
    checks++;
    if (sent_count !== 16'd26 || enable_out !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stream_sent: got sent=%0d en=%b pending=%0d required 26 0 0",
               sent_count, enable_out, exp_q.size());
    end
  endtask

  task automatic test_stall();
    clear_stall = 1'b1;
    step();
    clear_stall = 1'b0;
    checks++;
    if (stall_flag !== 1'b0) begin
      failures++;
      $display("FAIL stall_clear0: got %b required 0", stall_flag);
    end
    ready_in = 1'b0;
    src_data = 64'h5757_5757_5757_5757;
    src_tag = 4'hA;
    src_valid = 1'b1;
    step();
    src_valid = 1'b0;
    step();
    for (int i = 1; i <= SL; i++) begin
      step();
      checks++;
      if (stall_flag !== (i == SL)) begin
        failures++;
        $display("FAIL stall_count: blocked edge %0d got %b required %b", i, stall_flag, (i == SL));
      end
    end
    clear_stall = 1'b1;
    step();
    clear_stall = 1'b0;
    checks++;
    if (stall_flag !== 1'b1) begin
      failures++;
      $display("FAIL stall_set_wins: got %b required 1", stall_flag);
    end
    ready_in = 1'b1;
    step();
    checks++;
    if (stall_flag !== 1'b1 || enable_out !== 1'b0) begin
      failures++;
      $display("FAIL stall_sticky: got flag=%b en=%b required 1 0", stall_flag, enable_out);
    end
    clear_stall = 1'b1;
    step();
    clear_stall = 1'b0;
    checks++;
    if (stall_flag !== 1'b0) begin
      failures++;
      $display("FAIL stall_clear: got %b required 0", stall_flag);
    end
  endtask

  task automatic test_reset_mid();
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_data = 64'hBAD0_0000_0000_0000 + 64'(i);
      src_tag = 4'(i);
      src_valid = 1'b1;
      step();
    end
    src_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd3 || enable_out !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup: got cnt=%0d en=%b required 3 1", fifo_count, enable_out);
    end
    reset = 1'b0;
    #1;
    sb_on = 1'b0;
    exp_q.delete();
    checks++;
    if (enable_out !== 1'b0 || data_out !== '0 || tag_out !== '0 || fifo_count !== 3'd0
        || sent_count !== '0 || stall_flag !== 1'b0) begin
      failures++;
      $display("FAIL mid_async: got en=%b d=%h t=%h cnt=%0d sent=%0d stall=%b required all 0",
               enable_out, data_out, tag_out, fifo_count, sent_count, stall_flag);
    end
    repeat (2) step();
    reset = 1'b1;
    ready_in = 1'b1;
    sb_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (enable_out !== 1'b0 || fifo_count !== 3'd0 || sent_count !== '0) begin
        failures++;
        $display("FAIL mid_stale: got en=%b cnt=%0d sent=%0d required 0 0 0",
                 enable_out, fifo_count, sent_count);
      end
    end
    src_data = 64'h0123_4567_89AB_CDEF;
    src_tag = 4'hF;
    src_valid = 1'b1;
    step();
    src_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (sent_count !== 16'd1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_recover: got sent=%0d pending=%0d required 1 0", sent_count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/gin_bus_sender.md
Name: gin_bus_sender

Overview:
- Transmitting end of the GIN tagged-multicast bus.
- Accepts (data, tag) words from a source buffer through a valid/ready handshake and queues them in a small FIFO.
- Drives data/tag/enable onto the bus and holds each word until the aggregated ready returned by the downstream multicast controllers completes the transfer.
- Counts delivered words and flags stalled transfers for debug.

Parameters:
DATA_WIDTH, 64, bus data width
TAG_WIDTH, 4, tag width (row/column ID space)
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_WIDTH, 16, width of sent-word counter
STALL_LIMIT, 255, consecutive blocked cycles before stall_flag sets; >= 1

Ports:
link_clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
src_data  input  DATA_WIDTH  word from source
src_tag  input  TAG_WIDTH  destination tag for src_data
src_valid  input  1  source word valid
src_ready  output  1  FIFO can accept a word
data_out  output  DATA_WIDTH  bus data; all zeros when enable_out=0
tag_out  output  TAG_WIDTH  bus tag; all zeros when enable_out=0
enable_out  output  1  bus word valid
ready_in  input  1  aggregated ready from multicast controllers
fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy
sent_count  output  CNT_WIDTH  completed bus transfers, wraps
stall_flag  output  1  sticky stall indicator
clear_stall  input  1  synchronous clear of stall_flag

Behaviour:
- Reset (reset=0, asynchronous):
  - data_out=0, tag_out=0, enable_out=0, fifo_count=0, sent_count=0, stall_flag=0, stall counter=0.
  - FIFO pointers reset to 0; src_ready=1 one cycle after reset deasserts and combinationally thereafter.
  - Reset mid-transfer discards the held word and all FIFO contents; no partial word is ever presented.
- Push:
  - src_ready = (fifo_count != DEPTH), combinational from registered state.
  - A word is written on an edge where src_valid && src_ready.
  - When full, the word is not accepted even if a pop occurs in the same cycle.
- Bus transfer:
  - A transfer completes on the rising edge where enable_out && ready_in.
  - While enable_out=1 and ready_in=0, data_out/tag_out/enable_out hold stable.
- Output register load, each edge:
  - If (!enable_out || ready_in) and the FIFO is non-empty: load head to data_out/tag_out, set enable_out=1, pop.
  - Else if enable_out && ready_in and the FIFO is empty: enable_out=0 and data_out/tag_out=0.
  - Otherwise hold.
- Throughput: back-to-back words stream at one per cycle while ready_in stays 1.
- Latency: a word pushed at edge N into an empty FIFO with a free output register appears on the bus after edge N+1.
- Simultaneous push and pop (not full): both occur; fifo_count unchanged.
- Pointer arithmetic: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; fifo_count never exceeds DEPTH or goes below 0.
- sent_count: +1 on each completed transfer; wraps from 2^CNT_WIDTH-1 to 0.
- Stall logic:
  - The stall counter increments on each edge where enable_out && !ready_in, saturating at STALL_LIMIT.
  - It clears to 0 on a completed transfer or when enable_out=0.
  - stall_flag sets on the edge the counter reaches STALL_LIMIT and stays set until clear_stall=1 at an edge.
  - If set and clear happen on the same edge, set wins.
- ready_in is ignored while enable_out=0.
- All outputs are registered except src_ready.

Test Plan:
- Reset then idle: hold reset=0 3 cycles, release, src_valid=0 -> enable_out=0, data_out=0, tag_out=0, src_ready=1, fifo_count=0, sent_count=0.
- Single word: push data=64'hDEAD_BEEF_0000_0001, tag=4'h3 with ready_in=1 -> enable_out=1, data_out/tag_out match one edge later for exactly 1 cycle; sent_count=1.
- Backpressure and full: ready_in=0, push 6 words -> first 5 accepted (1 in output reg, 4 in FIFO); src_ready=0 with fifo_count=4; outputs stable. Raise ready_in -> 5 words emerge in order on consecutive cycles; sent_count=5.
- Streaming with simultaneous push/pop: continuous pushes with ready_in=1 for 20 cycles -> one word per cycle, fifo_count constant, order preserved, sent_count=20.
- Stall flag: STALL_LIMIT=8, hold ready_in=0 with a word presented -> stall_flag=1 after 8th blocked edge. Pulse clear_stall while still blocked -> flag stays 1 (counter saturated, set wins). Release ready_in, then clear_stall -> 0.
- Reset mid-operation: FIFO holding 3 words, enable_out=1, assert reset -> all outputs 0 immediately. After release, no stale words appear; sent_count=0.
